cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  Coprocessor-0 register file for the 5-stage MIPS pipeline: holds SR(12), Cause(13), EPC(14), PRId(15).
//  Services mfc0/mtc0, detects interrupts/exceptions at the commit point (M stage), saves victim PC to EPC.
//  Its EPC output feeds the eret EPC-forwarding mux; DOut feeds the M-stage mfc0 result path.
//  Two-state mode machine: NORMAL (EXL=0) / HANDLER (EXL=1).
// PARAMETERS
//  PRID      32'h0018_0000  constant returned on read of reg 15
//  NUM_HWINT 6              hardware interrupt lines, mapped to SR.IM/Cause.IP bits [15:10]
// PORTS
//  clk      in  1   rising-edge clock, sole clock
//  rst_n    in  1   synchronous active-low reset
//  A1       in  5   mfc0 read address (rd field)
//  A2       in  5   mtc0 write address (rd field)
//  DIn      in  32  mtc0 write data
//  WE       in  1   mtc0 write enable (M stage)
//  PC       in  32  PC of instruction in M stage
//  BD       in  1   M-stage instruction is in a branch delay slot
//  ExcCodeIn in 5   synchronous exception code from pipeline, 0 = none
//  EXLClr   in  1   eret in M stage
//  HWInt    in  6   external interrupt lines, level-sensitive
//  IntReq   out 1   take exception/interrupt this cycle (flush + redirect to handler)
//  EPC      out 32  current EPC register, bits[1:0] always 0
//  DOut     out 32  combinational read data for A1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): SR=0, Cause=0, EPC=0; mode NORMAL. IntReq=0 until rst_n=1 (outputs combinational from regs).
//  SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0, writes to them ignored.
//  Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; others read 0. Cause not writable by mtc0.
//  IP <= HWInt every cycle (1-cycle registered sample), regardless of mode.
//  hw_take  = IE & ~EXL & |(HWInt & IM)   (uses live HWInt, not IP)
//  exc_take = (ExcCodeIn != 0) & ~EXL
//  IntReq   = hw_take | exc_take ; combinational, same cycle.
//  On IntReq posedge: EXL<=1; Cause.BD<=BD; ExcCode<= hw_take ? 5'd0 : ExcCodeIn (interrupt has priority);
//    EPC <= BD ? {PC[31:2]-30'd1,2'b00} : {PC[31:2],2'b00} (PC-4 wraps mod 2^32).
//  mtc0 (WE=1, IntReq=0): A2=12 -> SR writable bits <= DIn; A2=14 -> EPC <= {DIn[31:2],2'b00};
//    other A2 values ignored. WE with IntReq=1 in same cycle: write discarded, exception update wins.
//  eret (EXLClr=1): EXL<=0 -> NORMAL. IntReq is 0 this cycle (EXL=1 gates it); pending interrupt
//    may be taken earliest the next cycle. EXLClr with WE to SR same cycle: DIn applied, then EXL forced 0.
//  EXLClr while EXL=0: no effect.
//  Read: DOut = A1 12/13/14/15 -> SR/Cause/EPC/PRID, else 0. Read-during-write returns OLD value
//    (no internal bypass; the EPC forwarding mux downstream covers mtc0->eret hazards).
//  All register updates happen only at posedge clk; no other state.
// TESTING
//  Reset: rst_n=0 one cycle, HWInt=6'h3F -> SR=0, EPC=0, IntReq=0; next cycle Cause.IP=6'h3F, IntReq still 0.
//  Interrupt: mtc0 SR<=32'h0000_FC01, HWInt[2]=1, PC=32'h0000_3010, BD=0 -> IntReq=1 same cycle;
//    next cycle EPC=32'h0000_3010, ExcCode=0, EXL=1, IntReq=0.
//  Delay slot exception: ExcCodeIn=5'd12, PC=32'h0000_3008, BD=1 -> EPC=32'h0000_3004, Cause=32'h8000_0030.
//  Priority: ExcCodeIn=5'd4 with enabled HWInt[0] and WE=1,A2=14,DIn=32'hDEAD_BEEF same cycle ->
//    ExcCode=0, EPC=victim PC (not DEADBEEC).
//  mtc0/mfc0 EPC: WE=1,A2=14,DIn=32'h0000_4003 -> A1=14 reads old value that cycle, 32'h0000_4000 next; A1=15 -> PRID; A1=9 -> 0.
//  eret: EXL=1, HWInt pending+enabled, EXLClr=1 -> IntReq=0 that cycle, IntReq=1 following cycle.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file for the 5-stage MIPS pipeline.
// Holds SR (12), Cause (13), EPC (14) and the constant PRId (15). It services mfc0/mtc0 and
// decides at the M-stage commit point whether to take an interrupt or exception. When it takes
// one, it saves the victim PC into EPC.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   A1         mfc0 read address            DOut  combinational read data for A1
//   A2/DIn/WE  mtc0 write address/data/enable
//   PC/BD      M-stage PC and branch-delay-slot flag
//   ExcCodeIn  synchronous exception code (0 = none)
//   EXLClr     eret in M stage
//   HWInt      level-sensitive hardware interrupt lines
//   IntReq     take exception/interrupt this cycle
//   EPC        current EPC, word aligned
module cp0_regfile #(
    parameter logic [31:0] PRID      = 32'h0018_0000,
    parameter int unsigned NUM_HWINT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    input  logic [31:0]          DIn,
    input  logic                 WE,
    input  logic [31:0]          PC,
    input  logic                 BD,
    input  logic [4:0]           ExcCodeIn,
    input  logic                 EXLClr,
    input  logic [NUM_HWINT-1:0] HWInt,
    output logic                 IntReq,
    output logic [31:0]          EPC,
    output logic [31:0]          DOut
);

    // SR.IM and Cause.IP share this bit position.
    localparam int unsigned IpLsb = 10;

    // Mode machine: the mode register is SR.EXL.
    typedef enum logic [0:0] {StNormal, StHandler} mode_e;

    mode_e                mode_q, mode_d;
    logic [NUM_HWINT-1:0] im_q, im_d;
    logic                 ie_q, ie_d;
    logic [NUM_HWINT-1:0] ip_q;
    logic                 bd_q, bd_d;
    logic [4:0]           exc_q, exc_d;
    logic [29:0]          epc_q, epc_d;

    logic        exl;
    logic        hw_take;
    logic        exc_take;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_pc_lsb;

    assign exl      = (mode_q == StHandler);
    // The live lines are used here, not the registered IP copy, so a request is seen the same cycle.
    assign hw_take  = ie_q & ~exl & (|(HWInt & im_q));
    assign exc_take = (ExcCodeIn != 5'd0) & ~exl;
    assign IntReq   = hw_take | exc_take;

    assign sr_wr  = WE && (A2 == 5'd12);
    assign epc_wr = WE && (A2 == 5'd14);

    assign unused_pc_lsb = ^PC[1:0];

    always_comb begin
        mode_d = mode_q;
        im_d   = im_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        exc_d  = exc_q;
        epc_d  = epc_q;
        if (IntReq) begin
            // An exception entry overrides any mtc0 in the same cycle.
            mode_d = StHandler;
            bd_d   = BD;
            exc_d  = hw_take ? 5'd0 : ExcCodeIn;
            epc_d  = BD ? (PC[31:2] - 30'd1) : PC[31:2];
        end else begin
            if (sr_wr) begin
                im_d   = DIn[IpLsb +: NUM_HWINT];
                ie_d   = DIn[0];
                mode_d = DIn[1] ? StHandler : StNormal;
            end
            if (epc_wr) begin
                epc_d = DIn[31:2];
            end
            // eret wins over an SR write that sets EXL in the same cycle.
            if (EXLClr) begin
                mode_d = StNormal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= StNormal;
            im_q   <= '0;
            ie_q   <= 1'b0;
            ip_q   <= '0;
            bd_q   <= 1'b0;
            exc_q  <= 5'd0;
            epc_q  <= 30'd0;
        end else begin
            mode_q <= mode_d;
            im_q   <= im_d;
            ie_q   <= ie_d;
            ip_q   <= HWInt;
            bd_q   <= bd_d;
            exc_q  <= exc_d;
            epc_q  <= epc_d;
        end
    end

    always_comb begin
        sr_val                       = '0;
        sr_val[IpLsb +: NUM_HWINT]   = im_q;
        sr_val[1]                    = exl;
        sr_val[0]                    = ie_q;
        cause_val                    = '0;
        cause_val[31]                = bd_q;
        cause_val[IpLsb +: NUM_HWINT] = ip_q;
        cause_val[6:2]               = exc_q;
    end

    assign EPC = {epc_q, 2'b00};

    // Reads return the registered values; no write bypass.
    always_comb begin
        DOut = '0;
        unique case (A1)
            5'd12:   DOut = sr_val;
            5'd13:   DOut = cause_val;
            5'd14:   DOut = EPC;
            5'd15:   DOut = PRID;
            default: DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile. A register-level model tracks SR/Cause/EPC as whole 32-bit words
// and is compared every cycle. Directed steps add literal expectations that pin the model.
module tb_cp0_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int checks = 0;
    int passes = 0;
    bit chk_en = 0;

    cp0_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BD        (BD),
        .ExcCodeIn (ExcCodeIn),
        .EXLClr    (EXLClr),
        .HWInt     (HWInt),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;
    logic        m_hw, m_take;
    logic [31:0] m_sr_wr, m_sr_nx, m_dout;

    assign m_hw    = !m_sr[1] && m_sr[0] && ((({26'd0, HWInt} << 10) & m_sr & 32'h0000_FC00) != 0);
    assign m_take  = m_hw || (!m_sr[1] && ExcCodeIn != 5'd0);
    assign m_sr_wr = (WE && A2 == 5'd12) ? (DIn & 32'h0000_FC03) : m_sr;
    assign m_sr_nx = m_take ? (m_sr | 32'h2) : (EXLClr ? (m_sr_wr & ~32'h2) : m_sr_wr);
    assign m_dout  = (A1 == 5'd12) ? m_sr :
                     (A1 == 5'd13) ? m_cause :
                     (A1 == 5'd14) ? m_epc :
                     (A1 == 5'd15) ? 32'h0018_0000 : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sr    <= 32'h0;
            m_cause <= 32'h0;
            m_epc   <= 32'h0;
        end else begin
            m_sr <= m_sr_nx;
            if (m_take) begin
                m_cause <= ({31'd0, BD} << 31) | ({26'd0, HWInt} << 10)
                         | (m_hw ? 32'h0 : ({27'd0, ExcCodeIn} << 2));
                m_epc   <= (PC & ~32'h3) - (BD ? 32'd4 : 32'd0);
            end else begin
                m_cause <= (m_cause & 32'h8000_007C) | ({26'd0, HWInt} << 10);
                if (WE && A2 == 5'd14) m_epc <= DIn & ~32'h3;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_intreq", {31'd0, IntReq}, {31'd0, m_take});
            check("model_epc", EPC, m_epc);
            check("model_dout", DOut, m_dout);
        end
    end

    // Advance to just after the next rising edge and return control inputs to idle.
    task automatic nxt();
        @(posedge clk);
        #1;
        WE = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; BD = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; PC = 32'h0;
        BD = 1'b0; ExcCodeIn = 5'd0; EXLClr = 1'b0; HWInt = 6'h3F;

        // Reset edge
        nxt(); rst_n = 1'b1; chk_en = 1; A1 = 5'd12;
        at_neg();
        check("reset_sr", DOut, 32'h0);
        check("reset_epc", EPC, 32'h0);
        check("reset_intreq", {31'd0, IntReq}, 32'h0);
        nxt(); A1 = 5'd13;
        at_neg();
        check("reset_cause_ip", DOut, 32'h0000_FC00);
        check("reset_intreq2", {31'd0, IntReq}, 32'h0);

        // Enable interrupts, then HWInt[2] fires
        nxt(); HWInt = 6'b000100; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        at_neg();
        nxt(); PC = 32'h0000_3010;
        at_neg();
        check("int_take", {31'd0, IntReq}, 32'h1);
        nxt(); A1 = 5'd13;
        at_neg();
        check("int_epc", EPC, 32'h0000_3010);
        check("int_cause", DOut, 32'h0000_1000);
        check("int_handler_gate", {31'd0, IntReq}, 32'h0);
        nxt(); A1 = 5'd12;
        at_neg();
        check("int_sr_exl", DOut, 32'h0000_FC03);

        // eret with interrupt still pending
        nxt(); EXLClr = 1'b1;
        at_neg();
        check("eret_gate", {31'd0, IntReq}, 32'h0);
        nxt(); PC = 32'h0000_3020;
        at_neg();
        check("eret_retake", {31'd0, IntReq}, 32'h1);

        // Leave handler, then exception in a delay slot
        nxt(); EXLClr = 1'b1; HWInt = 6'h0;
        at_neg();
        nxt(); ExcCodeIn = 5'd12; PC = 32'h0000_3008; BD = 1'b1;
        at_neg();
        check("ds_take", {31'd0, IntReq}, 32'h1);
        nxt(); A1 = 5'd13;
        at_neg();
        check("ds_epc", EPC, 32'h0000_3004);
        check("ds_cause", DOut, 32'h8000_0030);

        // Priority: interrupt beats exception, exception entry beats mtc0 EPC
        nxt(); EXLClr = 1'b1; HWInt = 6'h01;
        at_neg();
        nxt(); ExcCodeIn = 5'd4; WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; PC = 32'h0000_3040;
        at_neg();
        check("prio_take", {31'd0, IntReq}, 32'h1);
        nxt(); A1 = 5'd14;
        at_neg();
        check("prio_epc", DOut, 32'h0000_3040);
        nxt(); A1 = 5'd13;
        at_neg();
        check("prio_cause", DOut, 32'h0000_0400);

        // mtc0/mfc0 EPC with read-during-write
        nxt(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_4003; A1 = 5'd14;
        at_neg();
        check("rdw_old", DOut, 32'h0000_3040);
        nxt(); A1 = 5'd14;
        at_neg();
        check("mtc0_epc", DOut, 32'h0000_4000);
        nxt(); A1 = 5'd15;
        at_neg();
        check("prid", DOut, 32'h0018_0000);
        nxt(); A1 = 5'd9;
        at_neg();
        check("unmapped", DOut, 32'h0);

        // eret together with SR write that sets EXL: EXL ends 0
        nxt(); EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0003;
        at_neg();
        nxt(); A1 = 5'd12;
        at_neg();
        check("eret_sr_write", DOut, 32'h0000_0001);
        check("im_masked", {31'd0, IntReq}, 32'h0);

        // Reserved SR bits ignored; Cause not writable
        nxt(); WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFE;
        at_neg();
        nxt(); WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; A1 = 5'd12;
        at_neg();
        check("sr_mask", DOut, 32'h0000_FC02);
        nxt(); A1 = 5'd13;
        at_neg();
        check("cause_ro", DOut, 32'h0000_0400);

        // PC-4 wrap on a delay-slot exception at address 0
        nxt(); EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
        at_neg();
        nxt(); ExcCodeIn = 5'd10; PC = 32'h0000_0002; BD = 1'b1;
        at_neg();
        nxt(); A1 = 5'd14;
        at_neg();
        check("epc_wrap", EPC, 32'hFFFF_FFFC);

        for (int i = 0; i < 4; i++) begin
            nxt(); HWInt = 6'(i * 11); A1 = 5'(12 + i);
            at_neg();
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
